// File: rtl/store_unit.sv
// store_unit: single-outstanding store path from the MEM stage to data memory.
// Decodes the store type, detects misaligned or reserved stores (raising a
// one-cycle ades pulse with the faulting address), and otherwise issues a
// lane-replicated write with byte strobes. It then tracks the memory handshake
// through the states IDLE, REQ and WAIT and pulses done on completion.
module store_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Store type encodings
  localparam logic [1:0] T_SB = 2'b00;
  localparam logic [1:0] T_SH = 2'b01;
  localparam logic [1:0] T_SW = 2'b10;

  // A store faults when its address is not naturally aligned; type 11 always faults.
  function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] lo);
    logic bad;
    case (typ)
      T_SB:    bad = 1'b0;
      T_SH:    bad = lo[0];
      T_SW:    bad = lo[1] | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables for the addressed lane(s).
  function automatic logic [3:0] lane_strobe(input logic [1:0] typ, input logic [1:0] lo);
    logic [3:0] strb;
    case (typ)
      T_SB: begin
        case (lo)
          2'b00:   strb = 4'b0001;
          2'b01:   strb = 4'b0010;
          2'b10:   strb = 4'b0100;
          2'b11:   strb = 4'b1000;
          default: strb = 4'b0000;
        endcase
      end
      T_SH:    strb = lo[1] ? 4'b1100 : 4'b0011;
      T_SW:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Write data replicated across every lane so memory can pick any byte lane.
  function automatic logic [31:0] lane_data(input logic [1:0] typ, input logic [31:0] data);
    logic [31:0] wd;
    case (typ)
      T_SB:    wd = {4{data[7:0]}};
      T_SH:    wd = {2{data[15:0]}};
      T_SW:    wd = data;
      default: wd = 32'h0000_0000;
    endcase
    return wd;
  endfunction

  // Memory size code: 0 byte, 1 half, 2 word.
  function automatic logic [1:0] size_code(input logic [1:0] typ);
    logic [1:0] sz;
    case (typ)
      T_SB:    sz = 2'd0;
      T_SH:    sz = 2'd1;
      T_SW:    sz = 2'd2;
      default: sz = 2'd0;
    endcase
    return sz;
  endfunction

  state_e      state_q;
  logic        st_ready_q;
  logic        ades_q;
  logic [31:0] badvaddr_q;
  logic        mem_req_q;
  logic        mem_wr_q;
  logic [1:0]  mem_size_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;
  logic        done_q;

  logic        accept_s;
  logic        fault_s;
  logic [3:0]  strb_s;
  logic [31:0] wdata_s;
  logic [1:0]  size_s;

  // Decode the incoming request; only meaningful when accept_s is high.
  always_comb begin
    accept_s = st_valid & st_ready_q;
    fault_s  = is_misaligned(st_type, st_addr[1:0]);
    strb_s   = lane_strobe(st_type, st_addr[1:0]);
    wdata_s  = lane_data(st_type, st_data);
    size_s   = size_code(st_type);
  end

  // Store FSM with all outputs registered; ades and done are single-cycle pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      st_ready_q  <= 1'b0;
      ades_q      <= 1'b0;
      badvaddr_q  <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      done_q      <= 1'b0;
    end else begin
      ades_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          st_ready_q <= 1'b1;
          if (accept_s) begin
            if (fault_s) begin
              // Faulting store: report it and stay ready for the next one.
              ades_q     <= 1'b1;
              badvaddr_q <= st_addr;
            end else begin
              state_q     <= S_REQ;
              st_ready_q  <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= st_addr;
              mem_size_q  <= size_s;
              mem_wstrb_q <= strb_s;
              mem_wdata_q <= wdata_s;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_REQ: begin
          // Request fields stay frozen until memory takes the address.
          if (mem_addr_ok) begin
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            if (mem_data_ok) begin
              state_q    <= S_IDLE;
              st_ready_q <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            state_q <= S_REQ;
          end
        end
        S_WAIT: begin
          if (mem_data_ok) begin
            state_q    <= S_IDLE;
            st_ready_q <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          st_ready_q <= 1'b1;
          mem_req_q  <= 1'b0;
          mem_wr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready  = st_ready_q;
  assign ades      = ades_q;
  assign badvaddr  = badvaddr_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed scenarios plus randomized traffic for store_unit,
// checked every cycle against a transaction-level model of the store path.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ades;
  logic [31:0] badvaddr;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic        done;

  store_unit dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_addr(st_addr), .st_data(st_data),
    .ades(ades), .badvaddr(badvaddr),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: is a store outstanding, has memory taken its address
  bit          m_rst;
  bit          m_busy;
  bit          m_addr_taken;
  logic        e_ready, e_ades, e_req, e_done;
  logic [31:0] e_bad, e_addr, e_wdata;
  logic [1:0]  e_size;
  logic [3:0]  e_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access width in bytes is 1 << type; misaligned when addr is not a multiple.
  function automatic logic m_fault(input logic [1:0] t, input logic [31:0] a);
    if (t == 2'd3) return 1'b1;
    return (a % (32'd1 << t)) != 32'd0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] t, input logic [31:0] a);
    int nb;
    int m;
    nb = 1 << t;
    m  = ((1 << nb) - 1) << int'(a % 32'd4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] d);
    if (t == 2'd0) return (d & 32'd255) * 32'h0101_0101;
    if (t == 2'd1) return (d & 32'd65535) * 32'h0001_0001;
    return d;
  endfunction

  task automatic model_reset();
    m_rst = 1'b1; m_busy = 1'b0; m_addr_taken = 1'b0;
    e_ready = 1'b0; e_ades = 1'b0; e_req = 1'b0; e_done = 1'b0;
    e_bad = 32'd0; e_addr = 32'd0; e_wdata = 32'd0; e_size = 2'd0; e_strb = 4'd0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (!resetn) begin
      model_reset();
    end else begin
      m_rst  = 1'b0;
      e_ades = 1'b0;
      e_done = 1'b0;
      if (!m_busy) begin
        if (st_valid && e_ready) begin
          if (m_fault(st_type, st_addr)) begin
            e_ades = 1'b1;
            e_bad  = st_addr;
          end else begin
            m_busy = 1'b1; m_addr_taken = 1'b0; e_req = 1'b1;
            e_addr = st_addr; e_size = st_type;
            e_strb = m_strb(st_type, st_addr);
            e_wdata = m_wdata(st_type, st_data);
          end
        end
      end else if (!m_addr_taken) begin
        if (mem_addr_ok) begin
          e_req = 1'b0;
          m_addr_taken = 1'b1;
          if (mem_data_ok) begin m_busy = 1'b0; e_done = 1'b1; end
        end
      end else if (mem_data_ok) begin
        m_busy = 1'b0; e_done = 1'b1;
      end
      e_ready = !m_busy;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic aok, input logic dok);
    st_valid = v; st_type = t; st_addr = a; st_data = d;
    mem_addr_ok = aok; mem_data_ok = dok;
  endtask

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    if (m_rst) begin
      chk("rst_ready", {31'd0, st_ready}, 32'd0);
      chk("rst_req",   {31'd0, mem_req},  32'd0);
      chk("rst_wr",    {31'd0, mem_wr},   32'd0);
      chk("rst_ades",  {31'd0, ades},     32'd0);
      chk("rst_done",  {31'd0, done},     32'd0);
      chk("rst_addr",  mem_addr,  32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_bad",   badvaddr,  32'd0);
      chk("rst_size",  {30'd0, mem_size},  32'd0);
      chk("rst_strb",  {28'd0, mem_wstrb}, 32'd0);
    end else begin
      chk("cmp_ready", {31'd0, st_ready}, {31'd0, e_ready});
      chk("cmp_ades",  {31'd0, ades},     {31'd0, e_ades});
      chk("cmp_done",  {31'd0, done},     {31'd0, e_done});
      chk("cmp_req",   {31'd0, mem_req},  {31'd0, e_req});
      if (e_req) begin
        chk("cmp_wr",    {31'd0, mem_wr},    32'd1);
        chk("cmp_addr",  mem_addr,  e_addr);
        chk("cmp_size",  {30'd0, mem_size},  {30'd0, e_size});
        chk("cmp_strb",  {28'd0, mem_wstrb}, {28'd0, e_strb});
        chk("cmp_wdata", mem_wdata, e_wdata);
      end
      if (e_ades) chk("cmp_bad", badvaddr, e_bad);
    end
  end

  initial begin
    int dcount;
    resetn = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    model_reset();
    repeat (3) tick();
    chk("lit_rst_ready", {31'd0, st_ready}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("lit_ready_after_rst", {31'd0, st_ready}, 32'd1);
    chk("model_ready_after_rst", {31'd0, e_ready}, 32'd1);

    // sb 0x1003, addr_ok+data_ok together: done at N+2
    drive(1'b1, 2'd0, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("sb_req",   {31'd0, mem_req}, 32'd1);
    chk("sb_strb",  {28'd0, mem_wstrb}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    chk("sb_size",  {30'd0, mem_size}, 32'd0);
    chk("model_sb_wdata", e_wdata, 32'hDDDD_DDDD);
    chk("model_sb_strb", {28'd0, e_strb}, 32'h8);
    tick();
    chk("sb_done",  {31'd0, done}, 32'd1);
    chk("sb_ready", {31'd0, st_ready}, 32'd1);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("sb_done_pulse", {31'd0, done}, 32'd0);

    // sh 0x2002 with 3 stall cycles, data_ok 2 cycles after addr_ok
    drive(1'b1, 2'd1, 32'h0000_2002, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_stall_req",   {31'd0, mem_req}, 32'd1);
      chk("sh_stall_addr",  mem_addr, 32'h0000_2002);
      chk("sh_stall_strb",  {28'd0, mem_wstrb}, 32'hC);
      chk("sh_stall_wdata", mem_wdata, 32'h5678_5678);
      mem_data_ok = (i == 1);
      tick();
      dcount += int'(done);
    end
    chk("model_sh_wdata", e_wdata, 32'h5678_5678);
    chk("sh_still_req", {31'd0, mem_req}, 32'd1);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick(); dcount += int'(done);
    chk("sh_wait_req", {31'd0, mem_req}, 32'd0);
    mem_addr_ok = 1'b0;
    tick(); dcount += int'(done);
    mem_data_ok = 1'b1;
    tick(); dcount += int'(done);
    chk("sh_done", {31'd0, done}, 32'd1);
    mem_data_ok = 1'b0;
    tick(); dcount += int'(done);
    chk("sh_done_count", dcount, 32'd1);

    // sw misaligned and reserved type: ades pulse, no memory request
    drive(1'b1, 2'd2, 32'h0000_3001, 32'hCAFE_F00D, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("sw_ades", {31'd0, ades}, 32'd1);
    chk("sw_bad", badvaddr, 32'h0000_3001);
    chk("sw_noreq", {31'd0, mem_req}, 32'd0);
    chk("sw_ready", {31'd0, st_ready}, 32'd1);
    tick();
    chk("sw_ades_pulse", {31'd0, ades}, 32'd0);
    drive(1'b1, 2'd3, 32'h0000_4000, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rsv_ades", {31'd0, ades}, 32'd1);
    chk("rsv_bad", badvaddr, 32'h0000_4000);
    chk("rsv_noreq", {31'd0, mem_req}, 32'd0);
    tick();

    // sw 0x5000, reset while waiting for data_ok, late data_ok ignored
    drive(1'b1, 2'd2, 32'h0000_5000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    resetn = 1'b0; model_reset();
    #1;
    chk("rstw_req", {31'd0, mem_req}, 32'd0);
    chk("rstw_ready", {31'd0, st_ready}, 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    mem_data_ok = 1'b1;
    tick();
    chk("rstw_late_dok", {31'd0, done}, 32'd0);
    mem_data_ok = 1'b0;
    tick();
    chk("rstw_no_done", {31'd0, done}, 32'd0);
    drive(1'b1, 2'd2, 32'h0000_5004, 32'h0BAD_F00D, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    chk("rstw_next_done", {31'd0, done}, 32'd1);

    // Reset while the request is still presented: mem_req must fall at once
    drive(1'b1, 2'd2, 32'h0000_5008, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rstr_req_before", {31'd0, mem_req}, 32'd1);
    resetn = 1'b0; model_reset();
    #1;
    chk("rstr_req_after", {31'd0, mem_req}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Back-to-back: second valid held, accepted in first's done cycle
    drive(1'b1, 2'd2, 32'h0000_6000, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd2, 32'h0000_7004, 32'h2222_2222, 1'b1, 1'b0);
    tick();
    chk("b2b_held_ready", {31'd0, st_ready}, 32'd0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    tick();
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_done_ready", {31'd0, st_ready}, 32'd1);
    mem_data_ok = 1'b0;
    tick();
    chk("b2b_req2", {31'd0, mem_req}, 32'd1);
    chk("b2b_addr2", mem_addr, 32'h0000_7004);
    chk("b2b_wdata2", mem_wdata, 32'h2222_2222);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      resetn      = ($urandom_range(0, 299) != 0);
      st_valid    = 1'($urandom_range(0, 1));
      st_type     = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
      st_addr     = $urandom();
      st_data     = $urandom();
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = 1'($urandom_range(0, 1));
      if (!resetn) model_reset();
      tick();
    end
    resetn = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
